// File: rtl/riscv_tag_exception_unit_pkg.sv
// Shared constants and types for the DIFT tag-check exception unit.
package riscv_tag_exception_unit_pkg;

  localparam int         TCR_TRAP_EN        = 0;
  localparam logic [4:0] TAG_EXC_CAUSE_BASE = 5'd24;
  localparam int         CAUSE_W            = 5;
  localparam int         LOG_W              = 37;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } tag_exc_state_e;

  function automatic logic [CAUSE_W-1:0] tag_exc_cause(input logic [CAUSE_W-1:0] idx);
    return TAG_EXC_CAUSE_BASE + idx;
  endfunction

endpackage

// File: rtl/riscv_tag_exception_unit_if.sv
// Trap handshake to the controller plus the CSR-side violation log view.
interface riscv_tag_exception_unit_if;
  import riscv_tag_exception_unit_pkg::*;

  logic               tag_exc_req_o;
  logic               tag_exc_ack_i;
  logic               tag_exc_done_i;
  logic [CAUSE_W-1:0] tag_exc_cause_o;
  logic [31:0]        tag_exc_pc_o;
  logic [31:0]        tag_exc_addr_o;
  logic               log_pop_i;
  logic [LOG_W-1:0]   log_data_o;
  logic               log_empty_o;
  logic               log_full_o;
  logic               log_ovf_o;
  logic [7:0]         missed_cnt_o;

  modport master (
    output tag_exc_req_o, tag_exc_cause_o, tag_exc_pc_o, tag_exc_addr_o,
    output log_data_o, log_empty_o, log_full_o, log_ovf_o, missed_cnt_o,
    input  tag_exc_ack_i, tag_exc_done_i, log_pop_i
  );

  modport slave (
    input  tag_exc_req_o, tag_exc_cause_o, tag_exc_pc_o, tag_exc_addr_o,
    input  log_data_o, log_empty_o, log_full_o, log_ovf_o, missed_cnt_o,
    output tag_exc_ack_i, tag_exc_done_i, log_pop_i
  );

endinterface

// File: rtl/riscv_tag_exc_log_fifo.sv
// Synchronous FIFO with simultaneous push/pop; a push into a full FIFO with no pop is dropped.
module riscv_tag_exc_log_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Extra pointer MSB tells a wrapped (full) FIFO apart from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = empty ? {WIDTH{1'b0}} : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/riscv_tag_exception_unit.sv
// Arbitrates DIFT check-unit exceptions, runs the trap handshake with the controller,
// and logs accepted violations for software to drain.
module riscv_tag_exception_unit
  import riscv_tag_exception_unit_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int LOG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         exc_src_i,
  input  logic                       exc_valid_i,
  input  logic [31:0]                exc_pc_i,
  input  logic [31:0]                exc_addr_i,
  input  logic [31:0]                tcr_i,
  riscv_tag_exception_unit_if.master bus
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  tag_exc_state_e     state;
  tag_exc_state_e     state_next;
  logic [IDX_W-1:0]   win_idx;
  logic               hit;
  logic               accept;
  logic               missed;
  logic               fifo_drop;
  logic               req;
  logic [CAUSE_W-1:0] cause;
  logic [CAUSE_W-1:0] cause_new;
  logic [31:0]        pc;
  logic [31:0]        addr;
  logic [7:0]         missed_cnt;
  logic               ovf;
  logic               tcr_unused;

  assign hit        = exc_valid_i & (|exc_src_i);
  assign accept     = hit & (state == IDLE);
  assign missed     = hit & (state != IDLE);
  assign cause_new  = tag_exc_cause(CAUSE_W'(win_idx));
  assign tcr_unused = ^tcr_i;

  // Scanning from the top down leaves the lowest set index (highest priority) as winner.
  always_comb begin
    win_idx = {IDX_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (exc_src_i[i]) win_idx = IDX_W'(i);
      else              win_idx = win_idx;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (hit && tcr_i[TCR_TRAP_EN]) state_next = REQ;
        else                           state_next = IDLE;
      end
      REQ: begin
        if (bus.tag_exc_ack_i) state_next = HANDLER;
        else                   state_next = REQ;
      end
      HANDLER: begin
        if (bus.tag_exc_done_i) state_next = IDLE;
        else                    state_next = HANDLER;
      end
      default: state_next = IDLE;
    endcase
  end

  // req is registered from the next state so it rises one cycle after the hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req        <= 1'b0;
      cause      <= {CAUSE_W{1'b0}};
      pc         <= 32'h0000_0000;
      addr       <= 32'h0000_0000;
      missed_cnt <= 8'd0;
      ovf        <= 1'b0;
    end else begin
      state <= state_next;
      req   <= (state_next == REQ);
      if (accept) begin
        cause <= cause_new;
        pc    <= exc_pc_i;
        addr  <= exc_addr_i;
      end
      if (missed && (missed_cnt != 8'hFF)) missed_cnt <= missed_cnt + 8'd1;
      if (fifo_drop) ovf <= 1'b1;
    end
  end

  riscv_tag_exc_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (LOG_W)
  ) u_log (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (bus.log_pop_i),
    .wdata ({cause_new, exc_pc_i}),
    .rdata (bus.log_data_o),
    .empty (bus.log_empty_o),
    .full  (bus.log_full_o),
    .drop  (fifo_drop)
  );

  assign bus.tag_exc_req_o   = req;
  assign bus.tag_exc_cause_o = cause;
  assign bus.tag_exc_pc_o    = pc;
  assign bus.tag_exc_addr_o  = addr;
  assign bus.log_ovf_o       = ovf;
  assign bus.missed_cnt_o    = missed_cnt;

endmodule
